// File: rtl/sga_control_unit.sv
// Snake Game Arcade control unit: Moore FSM that sequences a game
// (prepare, init, wait for a move, latch direction, write head, render, check)
// and drives every control input of the datapath. Outputs are registered and
// always reflect the state the FSM is currently in.
module sga_control_unit #(
   parameter logic [1:0] DIR_RESET      = 2'b00,
   parameter bit         REJECT_REVERSE = 1'b1
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       jogar,
   input  logic       parar,
   input  logic [3:0] buttons,
   input  logic       played,
   input  logic       end_play_time,
   input  logic       render_finish,
   input  logic       ate_apple,
   input  logic       size_full,
   output logic       restart,
   output logic       clear_size,
   output logic       count_size,
   output logic       load_size,
   output logic       render_clr,
   output logic       render_count,
   output logic       register_apple,
   output logic       reset_apple,
   output logic       count_play_time,
   output logic       register_head,
   output logic       reset_head,
   output logic       we_ram,
   output logic       mux_ram,
   output logic       recharge,
   output logic [1:0] direction,
   output logic       won,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      PREPARE    = 4'd1,
      INIT       = 4'd2,
      WAIT_PLAY  = 4'd3,
      LATCH_DIR  = 4'd4,
      CLR_ADDR   = 4'd5,
      REG_HEAD   = 4'd6,
      WRITE_HEAD = 4'd7,
      RENDER     = 4'd8,
      CHECK      = 4'd9,
      GROW       = 4'd10,
      WON_ST     = 4'd11
   } state_t;

   // Bit positions inside the registered control vector.
   localparam int B_WON       = 14;
   localparam int B_RESTART   = 13;
   localparam int B_CLR_SIZE  = 12;
   localparam int B_CNT_SIZE  = 11;
   localparam int B_LOAD_SIZE = 10;
   localparam int B_RND_CLR   = 9;
   localparam int B_RND_CNT   = 8;
   localparam int B_REG_APPLE = 7;
   localparam int B_RST_APPLE = 6;
   localparam int B_CNT_PLAY  = 5;
   localparam int B_REG_HEAD  = 4;
   localparam int B_RST_HEAD  = 3;
   localparam int B_WE_RAM    = 2;
   localparam int B_MUX_RAM   = 1;
   localparam int B_RECHARGE  = 0;

   state_t      state_r;
   state_t      next_s;
   logic [1:0]  dir_r;
   logic [1:0]  dir_next_s;
   logic [1:0]  cand_s;
   logic [14:0] ctrl_r;

   // Fixed-priority button encoder: [0] wins over [1] over [2] over [3].
   function automatic logic [1:0] button_code(input logic [3:0] b);
      logic [1:0] c;
      c = 2'b00;
      if (b[0])      c = 2'b00;
      else if (b[1]) c = 2'b01;
      else if (b[2]) c = 2'b10;
      else if (b[3]) c = 2'b11;
      else           c = 2'b00;
      return c;
   endfunction

   // Moore output decode for a given state.
   function automatic logic [14:0] decode_ctrl(input state_t s);
      logic [14:0] o;
      o = 15'd0;
      case (s)
         PREPARE: begin
            o[B_RESTART]   = 1'b1;
            o[B_CLR_SIZE]  = 1'b1;
            o[B_RST_APPLE] = 1'b1;
            o[B_RST_HEAD]  = 1'b1;
            o[B_RND_CLR]   = 1'b1;
         end
         INIT: begin
            o[B_LOAD_SIZE] = 1'b1;
            o[B_REG_APPLE] = 1'b1;
         end
         WAIT_PLAY:  o[B_CNT_PLAY] = 1'b1;
         CLR_ADDR:   o[B_RND_CLR]  = 1'b1;
         REG_HEAD:   o[B_REG_HEAD] = 1'b1;
         WRITE_HEAD: o[B_WE_RAM]   = 1'b1;
         RENDER: begin
            o[B_RND_CNT]  = 1'b1;
            o[B_MUX_RAM]  = 1'b1;
            o[B_RECHARGE] = 1'b1;
         end
         GROW: begin
            o[B_CNT_SIZE]  = 1'b1;
            o[B_REG_APPLE] = 1'b1;
         end
         WON_ST:  o[B_WON] = 1'b1;
         default: o = 15'd0;
      endcase
      return o;
   endfunction

   assign cand_s = button_code(buttons);

   // Next-state logic; parar aborts every active state back to IDLE.
   always_comb begin
      next_s = IDLE;
      if (parar && (state_r != IDLE)) begin
         next_s = IDLE;
      end else begin
         case (state_r)
            IDLE:       next_s = jogar ? PREPARE : IDLE;
            PREPARE:    next_s = INIT;
            INIT:       next_s = WAIT_PLAY;
            WAIT_PLAY: begin
               if (played)             next_s = LATCH_DIR;
               else if (end_play_time) next_s = CLR_ADDR;
               else                    next_s = WAIT_PLAY;
            end
            LATCH_DIR:  next_s = CLR_ADDR;
            CLR_ADDR:   next_s = REG_HEAD;
            REG_HEAD:   next_s = WRITE_HEAD;
            WRITE_HEAD: next_s = RENDER;
            RENDER:     next_s = render_finish ? CHECK : RENDER;
            CHECK: begin
               if (size_full)      next_s = WON_ST;
               else if (ate_apple) next_s = GROW;
               else                next_s = WAIT_PLAY;
            end
            GROW:       next_s = WAIT_PLAY;
            WON_ST:     next_s = jogar ? PREPARE : WON_ST;
            default:    next_s = IDLE;
         endcase
      end
   end

   // Direction update: reload on a new game, latch a legal button in LATCH_DIR.
   always_comb begin
      dir_next_s = dir_r;
      if (state_r == PREPARE) begin
         dir_next_s = DIR_RESET;
      end else if (state_r == LATCH_DIR) begin
         if (buttons == 4'b0000) begin
            dir_next_s = dir_r;
         end else if (REJECT_REVERSE && (cand_s == {dir_r[1], ~dir_r[0]})) begin
            dir_next_s = dir_r;
         end else begin
            dir_next_s = cand_s;
         end
      end else begin
         dir_next_s = dir_r;
      end
   end

   // State, direction and registered Moore outputs (decoded from the next state).
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         dir_r   <= DIR_RESET;
         ctrl_r  <= 15'd0;
      end else begin
         state_r <= next_s;
         dir_r   <= dir_next_s;
         ctrl_r  <= decode_ctrl(next_s);
      end
   end

   assign won             = ctrl_r[B_WON];
   assign restart         = ctrl_r[B_RESTART];
   assign clear_size      = ctrl_r[B_CLR_SIZE];
   assign count_size      = ctrl_r[B_CNT_SIZE];
   assign load_size       = ctrl_r[B_LOAD_SIZE];
   assign render_clr      = ctrl_r[B_RND_CLR];
   assign render_count    = ctrl_r[B_RND_CNT];
   assign register_apple  = ctrl_r[B_REG_APPLE];
   assign reset_apple     = ctrl_r[B_RST_APPLE];
   assign count_play_time = ctrl_r[B_CNT_PLAY];
   assign register_head   = ctrl_r[B_REG_HEAD];
   assign reset_head      = ctrl_r[B_RST_HEAD];
   assign we_ram          = ctrl_r[B_WE_RAM];
   assign mux_ram         = ctrl_r[B_MUX_RAM];
   assign recharge        = ctrl_r[B_RECHARGE];
   assign direction       = dir_r;
   assign db_estado       = state_r;

endmodule

// File: tb/tb_sga_control_unit.sv
// Randomized scoreboard bench for sga_control_unit. Two instances are driven
// with identical stimulus: one rejects reversing moves, one accepts them.
module tb_sga_control_unit;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       jogar, parar, played, end_play_time, render_finish, ate_apple, size_full;
   logic [3:0] buttons;

   logic [14:0] ctrl_o [2];
   logic [1:0]  dir_o  [2];
   logic [3:0]  st_o   [2];

   int tests = 0;
   int fails = 0;

   // Reference model state (per instance) and expected-response queues.
   int         st_m  [2];
   logic [1:0] dir_m [2];
   logic [20:0] q0[$];
   logic [20:0] q1[$];

   always #5 clock = ~clock;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic r_restart, r_clear_size, r_count_size, r_load_size, r_render_clr, r_render_count;
      logic r_register_apple, r_reset_apple, r_count_play_time, r_register_head, r_reset_head;
      logic r_we_ram, r_mux_ram, r_recharge, r_won;
      logic [1:0] r_direction;
      logic [3:0] r_db_estado;
      sga_control_unit #(.DIR_RESET(2'b00), .REJECT_REVERSE(g == 0 ? 1'b1 : 1'b0)) dut (
         .clock(clock), .reset_n(reset_n), .jogar(jogar), .parar(parar), .buttons(buttons),
         .played(played), .end_play_time(end_play_time), .render_finish(render_finish),
         .ate_apple(ate_apple), .size_full(size_full),
         .restart(r_restart), .clear_size(r_clear_size), .count_size(r_count_size),
         .load_size(r_load_size), .render_clr(r_render_clr), .render_count(r_render_count),
         .register_apple(r_register_apple), .reset_apple(r_reset_apple),
         .count_play_time(r_count_play_time), .register_head(r_register_head),
         .reset_head(r_reset_head), .we_ram(r_we_ram), .mux_ram(r_mux_ram),
         .recharge(r_recharge), .direction(r_direction), .won(r_won), .db_estado(r_db_estado));
      assign ctrl_o[g] = {r_won, r_restart, r_clear_size, r_count_size, r_load_size,
                          r_render_clr, r_render_count, r_register_apple, r_reset_apple,
                          r_count_play_time, r_register_head, r_reset_head, r_we_ram,
                          r_mux_ram, r_recharge};
      assign dir_o[g] = r_direction;
      assign st_o[g]  = r_db_estado;
   end

   // Expected control vector for a state code, written from the output table
   // as a list of asserted signals (order matches the ctrl_o concatenation).
   function automatic logic [14:0] exp_ctrl(input int s);
      logic [14:0] v;
      v = 15'd0;
      if (s == 1)  v = 15'b011001001001000; // restart clear_size render_clr reset_apple reset_head
      if (s == 2)  v = 15'b000010010000000; // load_size register_apple
      if (s == 3)  v = 15'b000000000100000; // count_play_time
      if (s == 5)  v = 15'b000001000000000; // render_clr
      if (s == 6)  v = 15'b000000000010000; // register_head
      if (s == 7)  v = 15'b000000000000100; // we_ram, mux_ram=0
      if (s == 8)  v = 15'b000000100000011; // render_count mux_ram recharge
      if (s == 10) v = 15'b000100010000000; // count_size register_apple
      if (s == 11) v = 15'b100000000000000; // won
      return v;
   endfunction

   // One game step of the reference model from the sampled inputs.
   task automatic model_step(input int k, input bit reject_rev);
      int s;
      int ns;
      int cand;
      s  = st_m[k];
      ns = s;
      if (!reset_n) begin
         st_m[k]  = 0;
         dir_m[k] = 2'b00;
         return;
      end
      if (s != 0 && parar) ns = 0;
      else if (s == 0)  ns = jogar ? 1 : 0;
      else if (s == 3)  ns = played ? 4 : (end_play_time ? 5 : 3);
      else if (s == 8)  ns = render_finish ? 9 : 8;
      else if (s == 9)  ns = size_full ? 11 : (ate_apple ? 10 : 3);
      else if (s == 10) ns = 3;
      else if (s == 11) ns = jogar ? 1 : 11;
      else              ns = s + 1;   // 1..2 and 4..7 advance linearly
      if (s == 1) dir_m[k] = 2'b00;
      if (s == 4 && buttons != 4'b0000) begin
         cand = 0;
         for (int i = 3; i >= 0; i--) if (buttons[i]) cand = i;
         // opposite = same axis (cand/2), different sign
         if (!(reject_rev && (cand / 2 == int'(dir_m[k]) / 2) && (cand != int'(dir_m[k]))))
            dir_m[k] = 2'(cand);
      end
      st_m[k] = ns;
   endtask

   // Model advances on every clock edge and pushes the expected response.
   always @(posedge clock) begin
      model_step(0, 1'b1);
      model_step(1, 1'b0);
      q0.push_back({4'(st_m[0]), dir_m[0], exp_ctrl(st_m[0])});
      q1.push_back({4'(st_m[1]), dir_m[1], exp_ctrl(st_m[1])});
   end

   task automatic compare(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: after each edge pop the expected response and compare.
   always begin
      logic [20:0] e;
      @(posedge clock);
      #1;
      for (int k = 0; k < 2; k++) begin
         if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty: inst %0d has no expected entry", k);
         end else begin
            e = (k == 0) ? q0.pop_front() : q1.pop_front();
            compare(k == 0 ? "db_estado_rr1" : "db_estado_rr0", int'(st_o[k]), int'(e[20:17]));
            compare(k == 0 ? "direction_rr1" : "direction_rr0", int'(dir_o[k]), int'(e[16:15]));
            compare(k == 0 ? "ctrl_rr1" : "ctrl_rr0", int'(ctrl_o[k]), int'(e[14:0]));
         end
      end
   end

   int resets_done = 0;

   initial begin
      reset_n = 1'b0;
      {jogar, parar, played, end_play_time, render_finish, ate_apple, size_full} = 7'd0;
      buttons = 4'b0000;
      st_m[0] = 0; st_m[1] = 0; dir_m[0] = 2'b00; dir_m[1] = 2'b00;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clock);
         jogar         = ($urandom_range(0, 1) == 0);
         parar         = (st_m[0] != 1 && st_m[0] != 4) && ($urandom_range(0, 49) == 0);
         played        = ($urandom_range(0, 3) == 0);
         end_play_time = ($urandom_range(0, 5) == 0);
         render_finish = ($urandom_range(0, 4) == 0);
         ate_apple     = ($urandom_range(0, 2) == 0);
         size_full     = ($urandom_range(0, 7) == 0);
         buttons       = ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
         if (resets_done < 3 && st_m[0] == 8 && cyc > 300 * (resets_done + 1)) begin
            // asynchronous reset mid-RENDER: outputs must clear with no clock edge
            #2 reset_n = 1'b0;
            #1;
            for (int k = 0; k < 2; k++) begin
               compare("async_rst_state", int'(st_o[k]), 0);
               compare("async_rst_dir", int'(dir_o[k]), 0);
               compare("async_rst_ctrl", int'(ctrl_o[k]), 0);
            end
            resets_done++;
            @(negedge clock);
            reset_n = 1'b1;
         end
      end
      repeat (3) @(negedge clock);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
